imem_boot_loader: RTL and testbench

- Boot-time sequencer for the single-cycle core's instruction memory.
- After reset it holds the core stopped and accepts a byte stream from a UART/host front end. It assembles little-endian 32-bit words and drives the instruction memory write port.
- When the image is loaded it releases the core. A reload request re-enters loading without a reset.

---
 rtl/imem_boot_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Boot-time instruction-memory loader. Holds the core stopped,
//            receives a length header plus little-endian 32-bit words over a
//            byte stream, writes them into instruction memory, then releases
//            the core. A reload request from RUN restarts loading.
//            Optional checksum stage enabled by IMEM_BOOT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [LEN_W-1:0]  words_loaded
);

`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_RUN  = 3'd4,
        S_CSUM = 3'd5,
        S_ERR  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_RUN  = 3'd4
    } state_t;
`endif

    // First word index that no longer fits in the memory.
    localparam logic [LEN_W:0] c_DEPTH = (LEN_W + 1)'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [LEN_W-1:0]    widx_q, widx_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic w_xfer;
    logic w_last_word;
    logic w_overflow;
    logic w_len_zero;

    assign w_xfer      = rx_valid && rx_ready;
    assign w_last_word = (widx_q == (len_q - 1'b1));
    assign w_overflow  = ({1'b0, widx_q} >= c_DEPTH);
    assign w_len_zero  = (rx_data == 8'h00) && (len_q[7:0] == 8'h00);

    assign im_we        = we_q;
    assign im_waddr     = waddr_q;
    assign im_wdata     = wdata_q;
    assign cpu_run      = (state_q == S_RUN);
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = widx_q;

    // Next-state, byte assembly and write-port decisions.
    always_comb begin
        logic restart;
        restart    = 1'b0;
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        widx_d     = widx_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rx_ready   = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_LEN0: begin
                rx_ready = 1'b1;
                if (w_xfer) begin
                    len_d   = LEN_W'(rx_data);
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                rx_ready = 1'b1;
                if (w_xfer) begin
                    len_d[15:8] = rx_data;
                    if (w_len_zero) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (w_xfer) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    byte_idx_d = byte_idx_q + 1'b1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            // Word complete: the write appears next cycle.
                            // Words past the memory end are swallowed.
                            wdata_d = {rx_data, asm_q};
                            waddr_d = widx_q[ADDR_W-1:0];
                            widx_d  = widx_q + 1'b1;
                            if (w_overflow) begin
                                err_d = 1'b1;
                            end else begin
                                we_d = 1'b1;
                            end
                            if (w_last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                                state_d = S_CSUM;
`else
                                state_d = S_DONE;
`endif
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                if (w_xfer) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ERR: begin
                restart = reload;
            end
`endif
            S_DONE: begin
                // Lets the final memory write land before the core starts.
                state_d = S_RUN;
                done_d  = 1'b1;
            end
            S_RUN: begin
                restart = reload;
            end
            default: begin
                state_d = S_LEN0;
            end
        endcase

        if (restart) begin
            state_d    = S_LEN0;
            len_d      = '0;
            byte_idx_d = 2'd0;
            asm_d      = 24'h0;
            widx_d     = '0;
            err_d      = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_d     = 8'h00;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LEN0;
            len_q      <= '0;
            byte_idx_q <= 2'd0;
            asm_q      <= 24'h0;
            widx_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            widx_q     <= widx_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Self-checking bench for imem_boot_loader (ADDR_W = 2 so the
//            overflow boundary is reachable). Table-driven cycle vectors plus
//            hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int c_ADDR_W = 2;
    localparam int c_LEN_W  = 16;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam bit c_CSUM_ON = 1'b1;
`else
    localparam bit c_CSUM_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic                reload = 1'b0;
    logic                im_we;
    logic [c_ADDR_W-1:0] im_waddr;
    logic [31:0]         im_wdata;
    logic                cpu_run;
    logic                load_done;
    logic                load_err;
    logic [c_LEN_W-1:0]  words_loaded;

    imem_boot_loader #(
        .ADDR_W(c_ADDR_W),
        .LEN_W (c_LEN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .reload      (reload),
        .im_we       (im_we),
        .im_waddr    (im_waddr),
        .im_wdata    (im_wdata),
        .cpu_run     (cpu_run),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [7:0]  tb_csum;
    logic [33:0] wq[$];

    // Record every memory write seen mid-cycle.
    always @(negedge clk) begin
        if (!reset && im_we) wq.push_back({im_waddr, im_wdata});
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rl;
        logic        rdy;
        logic        we;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic        run;
        logic        dn;
        logic        err;
        logic [15:0] wl;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [7:0] d, input logic rl,
                           input logic rdy, input logic we, input logic [1:0] wa,
                           input logic [31:0] wd, input logic run, input logic dn,
                           input logic err, input logic [15:0] wl);
        vec_t t;
        t.v = v; t.d = d; t.rl = rl; t.rdy = rdy; t.we = we; t.wa = wa;
        t.wd = wd; t.run = run; t.dn = dn; t.err = err; t.wl = wl;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one byte from a negedge; returns at a negedge with rx_valid low.
    task automatic send(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        tb_csum  = tb_csum;
        k = 0;
        #1;
        while (!rx_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!rx_ready) begin
            n_total++;
            n_bad++;
            $display("FAIL send timeout: rx_ready=%b required 1", rx_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            tb_csum = tb_csum ^ w[8*i +: 8];
            send(w[8*i +: 8]);
        end
    endtask

    task automatic send_header(input logic [15:0] n);
        tb_csum = 8'h00;
        send(n[7:0]);
        send(n[15:8]);
    endtask

    task automatic send_csum();
        if (c_CSUM_ON) send(tb_csum);
    endtask

    task automatic wait_run(input string name, input int budget);
        int k;
        k = 0;
        while (!cpu_run && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {63'h0, cpu_run}, 64'h1);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    initial begin
        logic       rdy_ok;
        logic [7:0] bytes_n1[4];

        // ---------------- vector table ----------------
        // Basic two-word load.
        add_vec(1, 8'h02, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h13, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h03, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h08, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h83, 0, 1, 1, 0, 32'h08000313, 0, 0, 0, 1);
        add_vec(1, 8'h23, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add_vec(1, 8'h03, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        if (c_CSUM_ON) begin
            add_vec(1, 8'hBB, 0, 1, 1, 1, 32'h00032383, 0, 0, 0, 2);
            add_vec(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        end else begin
            add_vec(0, 8'h00, 0, 0, 1, 1, 32'h00032383, 0, 0, 0, 2);
        end
        add_vec(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 2);
        add_vec(1, 8'hAA, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add_vec(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 2);
        // After reload: N=1, reload ignored while in DATA.
        add_vec(1, 8'h01, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h13, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        if (c_CSUM_ON) begin
            add_vec(1, 8'h13, 0, 1, 1, 0, 32'h00000013, 0, 0, 0, 1);
            add_vec(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        end else begin
            add_vec(0, 8'h00, 0, 0, 1, 0, 32'h00000013, 0, 0, 0, 1);
        end
        add_vec(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        add_vec(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        // Empty image.
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        if (c_CSUM_ON) add_vec(1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        add_vec(0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // ---------------- reset state ----------------
        @(negedge clk);
        check("reset state",
              {9'h0, rx_ready, im_we, cpu_run, load_done, load_err, im_waddr, im_wdata, words_loaded},
              {9'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 16'h0});
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            reload   = vecs[i].rl;
            #1;
            check($sformatf("vec%0d flags", i),
                  {43'h0, rx_ready, im_we, cpu_run, load_done, load_err, words_loaded},
                  {43'h0, vecs[i].rdy, vecs[i].we, vecs[i].run, vecs[i].dn, vecs[i].err, vecs[i].wl});
            if (vecs[i].we)
                check($sformatf("vec%0d write", i), {30'h0, im_waddr, im_wdata},
                      {30'h0, vecs[i].wa, vecs[i].wd});
            @(negedge clk);
        end
        rx_valid = 1'b0;
        reload   = 1'b0;

        // ---------------- stalled stream ----------------
        do_reset();
        wq.delete();
        rdy_ok = 1'b1;
        tb_csum = 8'h00;
        bytes_n1[0] = 8'h37; bytes_n1[1] = 8'h52; bytes_n1[2] = 8'h34; bytes_n1[3] = 8'h12;
        send_header(16'd1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 5; g++) begin
                @(negedge clk);
                if (!rx_ready) rdy_ok = 1'b0;
            end
            tb_csum = tb_csum ^ bytes_n1[i];
            send(bytes_n1[i]);
        end
        send_csum();
        wait_run("stall run", 10);
        check("stall rdy held", {63'h0, rdy_ok}, 64'h1);
        check("stall write count", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) check("stall write", 64'(wq[0]), {30'h0, 2'b00, 32'h12345237});
        check("stall words", 64'(words_loaded), 64'd1);

        // ---------------- overflow ----------------
        do_reset();
        wq.delete();
        send_header(16'd5);
        for (int k = 0; k < 5; k++) send_word(32'hC0DE0000 + 32'(k));
        send_csum();
        wait_run("ovf run", 10);
        check("ovf write count", 64'(wq.size()), 64'd4);
        for (int k = 0; k < 4 && k < wq.size(); k++)
            check($sformatf("ovf write%0d", k), 64'(wq[k]),
                  {30'h0, 2'(k), 32'hC0DE0000 + 32'(k)});
        check("ovf err", {63'h0, load_err}, 64'h1);

        // ---------------- reset mid-load ----------------
        do_reset();
        send_header(16'd3);
        send_word(32'h44332211);
        send(8'h55);
        send(8'h66);
        wq.delete();
        reset = 1'b1;
        #1;
        check("midreset outputs", {58'h0, rx_ready, im_we, cpu_run, load_err, words_loaded[1:0]},
              {58'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset idle", {62'h0, cpu_run, rx_ready}, {62'h0, 1'b0, 1'b1});
        check("midreset no write", 64'(wq.size()), 64'd0);
        send_header(16'd1);
        send_word(32'hDEADBEEF);
        send_csum();
        wait_run("midreset reload run", 10);
        check("midreset write count", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) check("midreset write", 64'(wq[0]), {30'h0, 2'b00, 32'hDEADBEEF});

`ifdef IMEM_BOOT_CHECKSUM_EN
        // ---------------- checksum ----------------
        do_reset();
        send_header(16'd1);
        send_word(32'h00000013);
        send(8'h13);
        wait_run("csum good run", 10);
        check("csum good err", {63'h0, load_err}, 64'h0);
        pulse_reload();
        send_header(16'd1);
        send_word(32'h00000013);
        send(8'h14);
        repeat (3) @(negedge clk);
        check("csum bad state", {61'h0, load_err, cpu_run, rx_ready}, {61'h0, 1'b1, 1'b0, 1'b0});
        pulse_reload();
        #1;
        check("csum err reload", {61'h0, load_err, cpu_run, rx_ready}, {61'h0, 1'b0, 1'b0, 1'b1});
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
